// File: rtl/rp_link_pkg.sv
// Shared definitions for the static<->reconfigurable-partition stream link.
// Used by both the RP-side endpoint and the static-side region interface.
package rp_link_pkg;

    localparam int DEFAULT_DATA_W = 32;

    localparam logic [1:0] SKID_DEPTH = 2'd2;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        DRAIN    = 2'd1,
        QUIESCED = 2'd2
    } rp_state_e;

endpackage

// File: rtl/rp_skid_buffer.sv
// Two-entry registered valid/ready slice: full throughput, one cycle of latency,
// and an upstream ready that comes straight from a flop.
module rp_skid_buffer
    import rp_link_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              empty
);

    logic [DATA_W-1:0] head_data_r, head_data_s;
    logic              head_valid_r, head_valid_s;
    logic [DATA_W-1:0] spare_data_r, spare_data_s;
    logic              spare_valid_r, spare_valid_s;
    logic              ready_r, ready_s;
    logic              push_s, pop_s;
    logic [1:0]        fill_s;

    // Next-state of the two slots; the head slot always drives the output.
    always_comb begin
        push_s        = in_valid && ready_r;
        pop_s         = head_valid_r && out_ready;
        head_data_s   = head_data_r;
        head_valid_s  = head_valid_r;
        spare_data_s  = spare_data_r;
        spare_valid_s = spare_valid_r;
        if (pop_s && spare_valid_r) begin
            head_data_s  = spare_data_r;
            head_valid_s = 1'b1;
            if (push_s) begin
                spare_data_s = in_data;
            end else begin
                spare_valid_s = 1'b0;
            end
        end else if (pop_s) begin
            head_valid_s = push_s;
            if (push_s) begin
                head_data_s = in_data;
            end else begin
                head_data_s = head_data_r;
            end
        end else if (push_s && head_valid_r) begin
            spare_data_s  = in_data;
            spare_valid_s = 1'b1;
        end else if (push_s) begin
            head_data_s  = in_data;
            head_valid_s = 1'b1;
        end else begin
            head_valid_s = head_valid_r;
        end
        fill_s  = {1'b0, head_valid_s} + {1'b0, spare_valid_s};
        ready_s = (fill_s < SKID_DEPTH);
    end

    // Slot and ready registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            head_data_r   <= '0;
            head_valid_r  <= 1'b0;
            spare_data_r  <= '0;
            spare_valid_r <= 1'b0;
            ready_r       <= 1'b0;
        end else begin
            head_data_r   <= head_data_s;
            head_valid_r  <= head_valid_s;
            spare_data_r  <= spare_data_s;
            spare_valid_r <= spare_valid_s;
            ready_r       <= ready_s;
        end
    end

    assign in_ready  = ready_r;
    assign out_data  = head_data_r;
    assign out_valid = head_valid_r;
    assign empty     = !head_valid_r && !spare_valid_r;

endmodule

// File: rtl/rp_boundary_endpoint.sv
// RP-side terminator of the partition stream link: skid-buffered in both directions,
// in-flight accounting and a quiesce handshake for safe decouple/reconfigure.
module rp_boundary_endpoint
    import rp_link_pkg::*;
#(
    parameter  int DATA_W       = DEFAULT_DATA_W,
    parameter  int MAX_INFLIGHT = 16,
    localparam int CNT_W        = $clog2(MAX_INFLIGHT + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] rp_in_data,
    input  logic              rp_in_valid,
    output logic              rp_in_ready,
    output logic [DATA_W-1:0] rp_out_data,
    output logic              rp_out_valid,
    input  logic              rp_out_ready,
    output logic [DATA_W-1:0] core_in_data,
    output logic              core_in_valid,
    input  logic              core_in_ready,
    input  logic [DATA_W-1:0] core_out_data,
    input  logic              core_out_valid,
    output logic              core_out_ready,
    input  logic              quiesce_req,
    output logic              quiesce_ack,
    output logic [CNT_W-1:0]  inflight,
    output logic              err_underflow
);

    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_INFLIGHT);
    localparam logic [CNT_W-1:0] ONE_CNT = {{(CNT_W-1){1'b0}}, 1'b1};

    rp_state_e        state_r, state_s;
    logic [CNT_W-1:0] inflight_r, inflight_s;
    logic             err_r, err_s;
    logic             ack_r;
    logic             quiesced_s, gate_s;
    logic             ing_ready_s, ing_valid_s, ing_empty_s;
    logic             egr_ready_s, egr_valid_s, egr_empty_s;
    logic             in_xfer_s, out_xfer_s;

    // Intake and output masking depend only on registered state, keeping ready/valid glitch-free.
    assign quiesced_s = (state_r == QUIESCED);
    assign gate_s     = (state_r == RUN) && (inflight_r != MAX_CNT);

    rp_skid_buffer #(.DATA_W(DATA_W)) u_ingress (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (rp_in_data),
        .in_valid  (rp_in_valid && gate_s),
        .in_ready  (ing_ready_s),
        .out_data  (core_in_data),
        .out_valid (ing_valid_s),
        .out_ready (core_in_ready && !quiesced_s),
        .empty     (ing_empty_s)
    );

    rp_skid_buffer #(.DATA_W(DATA_W)) u_egress (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (core_out_data),
        .in_valid  (core_out_valid && !quiesced_s),
        .in_ready  (egr_ready_s),
        .out_data  (rp_out_data),
        .out_valid (egr_valid_s),
        .out_ready (rp_out_ready && !quiesced_s),
        .empty     (egr_empty_s)
    );

    assign rp_in_ready    = ing_ready_s && gate_s;
    assign core_in_valid  = ing_valid_s && !quiesced_s;
    assign core_out_ready = egr_ready_s && !quiesced_s;
    assign rp_out_valid   = egr_valid_s && !quiesced_s;
    assign in_xfer_s      = rp_in_valid && rp_in_ready;
    assign out_xfer_s     = rp_out_valid && rp_out_ready;

    // In-flight counter; an emit with nothing outstanding clamps at zero and flags underflow.
    always_comb begin
        inflight_s = inflight_r;
        err_s      = err_r;
        if (in_xfer_s && !out_xfer_s) begin
            inflight_s = inflight_r + ONE_CNT;
        end else if (out_xfer_s && (inflight_r == '0)) begin
            err_s = 1'b1;
        end else if (out_xfer_s && !in_xfer_s) begin
            inflight_s = inflight_r - ONE_CNT;
        end else begin
            inflight_s = inflight_r;
        end
    end

    // Quiesce FSM; a dropped request takes priority over drain completion.
    always_comb begin
        state_s = state_r;
        case (state_r)
            RUN: begin
                if (quiesce_req) state_s = DRAIN;
                else             state_s = RUN;
            end
            DRAIN: begin
                if (!quiesce_req)
                    state_s = RUN;
                else if ((inflight_r == '0) && ing_empty_s && egr_empty_s)
                    state_s = QUIESCED;
                else
                    state_s = DRAIN;
            end
            QUIESCED: begin
                if (!quiesce_req) state_s = RUN;
                else              state_s = QUIESCED;
            end
            default: state_s = RUN;
        endcase
    end

    // State, counter, sticky error and acknowledge registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r    <= RUN;
            inflight_r <= '0;
            err_r      <= 1'b0;
            ack_r      <= 1'b0;
        end else begin
            state_r    <= state_s;
            inflight_r <= inflight_s;
            err_r      <= err_s;
            ack_r      <= (state_s == QUIESCED);
        end
    end

    assign quiesce_ack   = ack_r;
    assign inflight      = inflight_r;
    assign err_underflow = err_r;

endmodule

// File: tb/tb_rp_boundary_endpoint.sv
// Self-checking bench for rp_boundary_endpoint: queue-based core model with +0x100 echo,
// scoreboard of expected rp_out beats, one task per scenario.
module tb_rp_boundary_endpoint;

    localparam int DATA_W = 32;
    localparam int CNT_W  = 5;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [DATA_W-1:0] rp_in_data = '0;
    logic              rp_in_valid = 1'b0;
    logic              rp_in_ready;
    logic [DATA_W-1:0] rp_out_data;
    logic              rp_out_valid;
    logic              rp_out_ready = 1'b0;
    logic [DATA_W-1:0] core_in_data;
    logic              core_in_valid;
    logic              core_in_ready = 1'b0;
    logic [DATA_W-1:0] core_out_data = '0;
    logic              core_out_valid = 1'b0;
    logic              core_out_ready;
    logic              quiesce_req = 1'b0;
    logic              quiesce_ack;
    logic [CNT_W-1:0]  inflight;
    logic              err_underflow;

    logic              core_rel = 1'b0;
    logic [31:0]       tx_q[$];
    logic [31:0]       sb[$];
    logic [31:0]       core_q[$];
    int                out_cyc[$];
    int                n_checks = 0;
    int                n_pass = 0;
    int                in_cnt = 0;
    int                out_cnt = 0;
    int                cycle = 0;

    rp_boundary_endpoint dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .rp_in_data     (rp_in_data),
        .rp_in_valid    (rp_in_valid),
        .rp_in_ready    (rp_in_ready),
        .rp_out_data    (rp_out_data),
        .rp_out_valid   (rp_out_valid),
        .rp_out_ready   (rp_out_ready),
        .core_in_data   (core_in_data),
        .core_in_valid  (core_in_valid),
        .core_in_ready  (core_in_ready),
        .core_out_data  (core_out_data),
        .core_out_valid (core_out_valid),
        .core_out_ready (core_out_ready),
        .quiesce_req    (quiesce_req),
        .quiesce_ack    (quiesce_ack),
        .inflight       (inflight),
        .err_underflow  (err_underflow)
    );

    always #5 clk = ~clk;

    // Handshake monitor: scoreboard push on rp_in, core model, scoreboard check on rp_out.
    always @(posedge clk) begin
        logic [31:0] want;
        cycle++;
        if (rp_in_valid && rp_in_ready) begin
            sb.push_back(rp_in_data + 32'h0000_0100);
            void'(tx_q.pop_front());
            in_cnt++;
        end
        if (core_in_valid && core_in_ready) core_q.push_back(core_in_data + 32'h0000_0100);
        if (core_out_valid && core_out_ready) void'(core_q.pop_front());
        if (rp_out_valid && rp_out_ready) begin
            out_cnt++;
            out_cyc.push_back(cycle);
            n_checks++;
            if (sb.size() == 0) begin
                $display("FAIL sb_unexpected: got %h, nothing expected", rp_out_data);
            end else begin
                want = sb.pop_front();
                if (rp_out_data !== want) $display("FAIL sb_data: got %h want %h", rp_out_data, want);
                else n_pass++;
            end
        end
    end

    // Input drivers, updated just after the falling edge from the bench queues.
    always @(negedge clk) begin
        #1;
        rp_in_valid    = (tx_q.size() != 0);
        rp_in_data     = (tx_q.size() != 0) ? tx_q[0] : 32'h0;
        core_out_valid = core_rel && (core_q.size() != 0);
        core_out_data  = (core_q.size() != 0) ? core_q[0] : 32'h0;
    end

    task automatic wait_cycles(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic wait_in(input int target, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (in_cnt >= target) begin ok = 1'b1; break; end
        end
    endtask

    task automatic wait_idle(input int max_cyc, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < max_cyc; i++) begin
            @(negedge clk);
            if (tx_q.size() == 0 && sb.size() == 0 && inflight == 5'd0) begin ok = 1'b1; break; end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        wait_cycles(3);
        n_checks++; if (rp_in_ready !== 1'b0) $display("FAIL reset_in_ready: got %b want 0", rp_in_ready); else n_pass++;
        n_checks++; if ({rp_out_valid, core_in_valid, core_out_ready, quiesce_ack} !== 4'b0000)
            $display("FAIL reset_flags: got %b want 0000", {rp_out_valid, core_in_valid, core_out_ready, quiesce_ack}); else n_pass++;
        n_checks++; if ({inflight, err_underflow} !== 6'd0) $display("FAIL reset_cnt: got %h want 0", {inflight, err_underflow}); else n_pass++;
        n_checks++; if ({rp_out_data, core_in_data} !== 64'd0) $display("FAIL reset_data: got %h want 0", {rp_out_data, core_in_data}); else n_pass++;
        rst_n = 1'b1;
        @(negedge clk);
        n_checks++; if (rp_in_ready !== 1'b1) $display("FAIL reset_release_ready: got %b want 1", rp_in_ready); else n_pass++;
    endtask

    task automatic test_back_to_back();
        int base, peak;
        bit ok;
        core_in_ready = 1'b1; core_rel = 1'b1; rp_out_ready = 1'b1;
        base = out_cnt; peak = 0;
        out_cyc.delete();
        for (int i = 1; i <= 8; i++) tx_q.push_back(32'(i));
        ok = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (int'(inflight) > peak) peak = int'(inflight);
            if (tx_q.size() == 0 && sb.size() == 0 && inflight == 5'd0 && out_cnt - base == 8) begin ok = 1'b1; break; end
        end
        n_checks++; if (!ok) $display("FAIL b2b_idle: timeout, out %0d want 8", out_cnt - base); else n_pass++;
        n_checks++; if (peak > 3 || peak == 0) $display("FAIL b2b_peak: got %0d want 1..3", peak); else n_pass++;
        n_checks++;
        if (out_cyc.size() != 8) $display("FAIL b2b_rate: got %0d beats want 8", out_cyc.size());
        else if (out_cyc[7] - out_cyc[0] != 7) $display("FAIL b2b_rate: span %0d cycles want 7", out_cyc[7] - out_cyc[0]);
        else n_pass++;
    endtask

    task automatic test_skid_backpressure();
        int in_base, out_base;
        bit ok;
        core_in_ready = 1'b0;
        in_base = in_cnt; out_base = out_cnt;
        for (int i = 0; i < 20; i++) tx_q.push_back(32'h0000_1000 + 32'(i));
        wait_cycles(6);
        n_checks++; if (in_cnt - in_base != 2) $display("FAIL skid_accepted: got %0d want 2", in_cnt - in_base); else n_pass++;
        n_checks++; if (rp_in_ready !== 1'b0) $display("FAIL skid_ready: got %b want 0", rp_in_ready); else n_pass++;
        core_in_ready = 1'b1;
        wait_idle(100, ok);
        n_checks++; if (!ok || out_cnt - out_base != 20) $display("FAIL skid_drain: got %0d beats want 20", out_cnt - out_base); else n_pass++;
    endtask

    task automatic test_inflight_limit();
        int in_base, out_base;
        bit ok;
        core_in_ready = 1'b1; core_rel = 1'b0; rp_out_ready = 1'b0;
        in_base = in_cnt; out_base = out_cnt;
        for (int i = 0; i < 20; i++) tx_q.push_back(32'h0000_2000 + 32'(i));
        wait_cycles(30);
        n_checks++; if (inflight !== 5'd16) $display("FAIL limit_inflight: got %0d want 16", inflight); else n_pass++;
        n_checks++; if (in_cnt - in_base != 16) $display("FAIL limit_accepted: got %0d want 16", in_cnt - in_base); else n_pass++;
        n_checks++; if (rp_in_ready !== 1'b0) $display("FAIL limit_ready: got %b want 0", rp_in_ready); else n_pass++;
        core_rel = 1'b1;
        wait_cycles(4);
        rp_out_ready = 1'b1;
        @(negedge clk);
        rp_out_ready = 1'b0;
        wait_cycles(5);
        n_checks++; if (in_cnt - in_base != 17 || out_cnt - out_base != 1)
            $display("FAIL limit_reopen: got in %0d out %0d want 17/1", in_cnt - in_base, out_cnt - out_base); else n_pass++;
        n_checks++; if (inflight !== 5'd16) $display("FAIL limit_refill: got %0d want 16", inflight); else n_pass++;
        rp_out_ready = 1'b1;
        wait_idle(100, ok);
        n_checks++; if (!ok || out_cnt - out_base != 20) $display("FAIL limit_drain: got %0d beats want 20", out_cnt - out_base); else n_pass++;
    endtask

    task automatic test_quiesce();
        int out_base;
        bit ok;
        core_in_ready = 1'b1; core_rel = 1'b0; rp_out_ready = 1'b1;
        out_base = out_cnt;
        for (int i = 0; i < 5; i++) tx_q.push_back(32'h0000_3000 + 32'(i));
        wait_in(in_cnt + 5, ok);
        n_checks++; if (!ok) $display("FAIL q_fill: timeout, %0d beats pending", tx_q.size()); else n_pass++;
        quiesce_req = 1'b1;
        @(negedge clk);
        n_checks++; if (rp_in_ready !== 1'b0) $display("FAIL q_intake_stop: got %b want 0", rp_in_ready); else n_pass++;
        core_rel = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (quiesce_ack === 1'b1) begin ok = 1'b1; break; end
        end
        n_checks++; if (!ok) $display("FAIL q_ack: timeout, got 0 want 1"); else n_pass++;
        n_checks++; if (out_cnt - out_base != 5 || inflight !== 5'd0)
            $display("FAIL q_drained: got out %0d inflight %0d want 5/0", out_cnt - out_base, inflight); else n_pass++;
        n_checks++; if ({rp_in_ready, core_out_ready, rp_out_valid, core_in_valid} !== 4'b0000)
            $display("FAIL q_masked: got %b want 0000", {rp_in_ready, core_out_ready, rp_out_valid, core_in_valid}); else n_pass++;
        quiesce_req = 1'b0;
        @(negedge clk);
        n_checks++; if ({quiesce_ack, rp_in_ready} !== 2'b01) $display("FAIL q_release: got ack/ready %b want 01", {quiesce_ack, rp_in_ready}); else n_pass++;
    endtask

    task automatic test_quiesce_abort();
        int out_base;
        bit ok, ack_seen;
        core_in_ready = 1'b1; core_rel = 1'b0; rp_out_ready = 1'b1;
        out_base = out_cnt; ack_seen = 1'b0;
        for (int i = 0; i < 3; i++) tx_q.push_back(32'h0000_4000 + 32'(i));
        wait_in(in_cnt + 3, ok);
        quiesce_req = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            if (quiesce_ack) ack_seen = 1'b1;
        end
        quiesce_req = 1'b0;
        @(negedge clk);
        if (quiesce_ack) ack_seen = 1'b1;
        n_checks++; if (rp_in_ready !== 1'b1) $display("FAIL abort_run: got ready %b want 1", rp_in_ready); else n_pass++;
        for (int i = 0; i < 2; i++) tx_q.push_back(32'h0000_4010 + 32'(i));
        core_rel = 1'b1;
        wait_idle(60, ok);
        if (quiesce_ack) ack_seen = 1'b1;
        n_checks++; if (!ok || out_cnt - out_base != 5) $display("FAIL abort_beats: got %0d want 5", out_cnt - out_base); else n_pass++;
        n_checks++; if (ack_seen) $display("FAIL abort_ack: got ack 1 want 0"); else n_pass++;
    endtask

    task automatic test_underflow_reset();
        bit ok;
        core_in_ready = 1'b1; core_rel = 1'b1; rp_out_ready = 1'b1;
        core_q.push_back(32'hDEAD_BEEF);
        sb.push_back(32'hDEAD_BEEF);
        wait_cycles(6);
        n_checks++; if ({err_underflow, inflight} !== 6'b1_00000) $display("FAIL uf_set: got err %b inflight %0d want 1/0", err_underflow, inflight); else n_pass++;
        wait_cycles(5);
        n_checks++; if (err_underflow !== 1'b1) $display("FAIL uf_sticky: got %b want 1", err_underflow); else n_pass++;
        quiesce_req = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (quiesce_ack === 1'b1) begin ok = 1'b1; break; end
        end
        n_checks++; if (!ok) $display("FAIL uf_quiesce: timeout, ack got 0 want 1"); else n_pass++;
        rst_n = 1'b0;
        @(negedge clk);
        n_checks++; if ({quiesce_ack, err_underflow, rp_in_ready} !== 3'b000)
            $display("FAIL rst_quiesced: got ack/err/ready %b want 000", {quiesce_ack, err_underflow, rp_in_ready}); else n_pass++;
        quiesce_req = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        n_checks++; if ({rp_in_ready, quiesce_ack, err_underflow} !== 3'b100)
            $display("FAIL rst_run: got ready/ack/err %b want 100", {rp_in_ready, quiesce_ack, err_underflow}); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_skid_backpressure();
        test_inflight_limit();
        test_quiesce();
        test_quiesce_abort();
        test_underflow_reset();
        wait_cycles(2);
        n_checks++; if (sb.size() != 0) $display("FAIL sb_leftover: got %0d pending want 0", sb.size()); else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
